// File: rtl/case_conv_pkg.sv
// Shared types, ASCII constants and the case-conversion function for the
// UART case-converter datapath.
package case_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_UPPER = 2'd1,
        MODE_LOWER = 2'd2,
        MODE_SWAP  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam logic [7:0] CASE_BIT   = 8'h20;

    function automatic logic [7:0] case_convert(input logic [7:0] b, input mode_e mode);
        logic is_uc;
        logic is_lc;
        is_uc = (b >= ASCII_UC_A) && (b <= ASCII_UC_Z);
        is_lc = (b >= ASCII_LC_A) && (b <= ASCII_LC_Z);
        case_convert = b;
        case (mode)
            MODE_UPPER: if (is_lc) case_convert = b - CASE_BIT;
            MODE_LOWER: if (is_uc) case_convert = b + CASE_BIT;
            MODE_SWAP: begin
                if (is_lc) case_convert = b - CASE_BIT;
                if (is_uc) case_convert = b + CASE_BIT;
            end
            default: case_convert = b;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and registered read data.
// A push into a full FIFO is ignored even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_case_ctrl.sv
// Sequences received bytes through a FIFO and the case converter into the
// transmitter via a start/busy handshake; overflow is counted, never stalled.
module uart_case_ctrl
    import case_conv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    input  logic [1:0]               i_mode,
    input  logic                     i_tx_busy,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_start,
    output logic                     o_overflow,
    output logic [CNT_W-1:0]         o_drop_cnt,
    output logic [$clog2(DEPTH)-1+1:0] o_level
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_e     state;
    state_e     state_nxt;
    mode_e      mode_q;
    logic       rx_valid_q;
    logic       armed;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] head;

    // armed stays low until rx_valid is seen low after reset, so a valid
    // already high at reset release is not taken as a new byte.
    assign push = i_rx_valid && !rx_valid_q && armed;

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk  (i_clk),
        .rst  (i_rst),
        .push (push),
        .wdata(i_rx_data),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty),
        .level(o_level)
    );

    // Both head and mode_q are captured at pop, so the output stays put until the next pop.
    assign o_tx_data = case_convert(head, mode_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_PASS;
            rx_valid_q <= 1'b0;
            armed      <= 1'b0;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            state      <= state_nxt;
            rx_valid_q <= i_rx_valid;
            armed      <= armed || !i_rx_valid;
            if (pop) mode_q <= mode_e'(i_mode);
            if (push && full) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        o_tx_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                o_tx_start = 1'b1;
                state_nxt  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK:  if (i_tx_busy)  state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!i_tx_busy) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    logic unused_lvl;
    assign unused_lvl = ^LVL_W;

endmodule
